// File: rtl/vga_sig_gen.sv
// VGA 640x480 timing generator reading a 320x240 1-bpp frame buffer (2x pixel
// doubling) with two-colour palette and a frame-end interrupt.
module vga_sig_gen #(
  parameter int CLK_DIV = 4,
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33
) (
  input  logic        CLK,
  input  logic        RESETN,
  output logic [16:0] VGA_ADDR,
  input  logic        VGA_DATA,
  input  logic [15:0] CONFIG_COLOURS,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic [7:0]  VGA_COLOUR,
  output logic        VGA_IRQ,
  input  logic        IRQ_ACK
);

  localparam int H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_VIS + H_FP;
  localparam int HS_STOP  = HS_START + H_SYNC;
  localparam int VS_START = V_VIS + V_FP;
  localparam int VS_STOP  = VS_START + V_SYNC;
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             tick_d1;
  logic             tick_d2;
  logic [9:0]       h_cnt;
  logic [9:0]       v_cnt;
  logic             h_last;
  logic             v_last;
  logic             visible;
  logic             hs_active;
  logic             vs_active;
  logic             irq_set;
  logic             pixel;

  assign tick      = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign h_last    = (h_cnt == 10'(H_TOTAL - 1));
  assign v_last    = (v_cnt == 10'(V_TOTAL - 1));
  assign visible   = (h_cnt < 10'(H_VIS)) && (v_cnt < 10'(V_VIS));
  assign hs_active = (h_cnt >= 10'(HS_START)) && (h_cnt < 10'(HS_STOP));
  assign vs_active = (v_cnt >= 10'(VS_START)) && (v_cnt < 10'(VS_STOP));
  // Counters hold the new position during the CLK after the tick that set them.
  assign irq_set   = tick_d1 && (h_cnt == 10'd0) && (v_cnt == 10'(V_VIS));

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else begin
      if (tick) begin
        div_cnt <= '0;
        if (h_last) begin
          h_cnt <= '0;
          v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  // Address goes out one CLK after the tick; the pixel comes back one CLK later.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      tick_d1  <= 1'b0;
      tick_d2  <= 1'b0;
      VGA_ADDR <= '0;
      pixel    <= 1'b0;
    end else begin
      tick_d1 <= tick;
      tick_d2 <= tick_d1;
      if (tick_d1) begin
        VGA_ADDR <= visible ? {v_cnt[8:1], h_cnt[9:1]} : 17'd0;
      end
      if (tick_d2) begin
        pixel <= VGA_DATA;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      VGA_HS     <= 1'b1;
      VGA_VS     <= 1'b1;
      VGA_COLOUR <= 8'h00;
    end else if (tick) begin
      VGA_HS <= !hs_active;
      VGA_VS <= !vs_active;
      if (!visible) begin
        VGA_COLOUR <= 8'h00;
      end else if (pixel) begin
        VGA_COLOUR <= CONFIG_COLOURS[15:8];
      end else begin
        VGA_COLOUR <= CONFIG_COLOURS[7:0];
      end
    end
  end

  // A new frame-end event wins over a simultaneous acknowledge.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      VGA_IRQ <= 1'b0;
    end else if (irq_set) begin
      VGA_IRQ <= 1'b1;
    end else if (IRQ_ACK) begin
      VGA_IRQ <= 1'b0;
    end
  end

endmodule
